// File: rtl/renkon_layer_seq.sv
// Layer sequencer for a renkon conv/bias/relu/pool core: walks a host-written
// descriptor table, presents each layer's config and handshakes req/ack with the core.
module renkon_layer_seq #(
  parameter int LWIDTH  = 10,
  parameter int MEMSIZE = 12,
  parameter int NETSIZE = 11,
  parameter int NLAYER  = 8,
  parameter int TIMEOUT = 2**20
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(NLAYER):0]   num_layers,
  input  logic                      abort,
  input  logic                      cfg_we,
  input  logic [$clog2(NLAYER)-1:0] cfg_layer,
  input  logic [3:0]                cfg_field,
  input  logic [15:0]               cfg_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      aborted,
  output logic [$clog2(NLAYER)-1:0] cur_layer,
  output logic                      req,
  input  logic                      ack,
  output logic [LWIDTH-1:0]         total_in,
  output logic [LWIDTH-1:0]         total_out,
  output logic [LWIDTH-1:0]         img_height,
  output logic [LWIDTH-1:0]         img_width,
  output logic [LWIDTH-1:0]         conv_kern,
  output logic [LWIDTH-1:0]         conv_strid,
  output logic [LWIDTH-1:0]         conv_pad,
  output logic [LWIDTH-1:0]         pool_kern,
  output logic [LWIDTH-1:0]         pool_strid,
  output logic [LWIDTH-1:0]         pool_pad,
  output logic                      bias_en,
  output logic                      relu_en,
  output logic                      pool_en,
  output logic [MEMSIZE-1:0]        in_offset,
  output logic [MEMSIZE-1:0]        out_offset,
  output logic [NETSIZE-1:0]        net_offset
);

  localparam int LI = $clog2(NLAYER);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [LI:0]   NMAX   = (LI+1)'(NLAYER);
  localparam logic [CW-1:0] TO_END = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  typedef struct packed {
    logic [LWIDTH-1:0]  total_in, total_out, img_height, img_width;
    logic [LWIDTH-1:0]  conv_kern, conv_strid, conv_pad;
    logic [LWIDTH-1:0]  pool_kern, pool_strid, pool_pad;
    logic               pool_en, relu_en, bias_en;
    logic [MEMSIZE-1:0] in_offset, out_offset;
    logic [NETSIZE-1:0] net_offset;
  } desc_t;

  desc_t         tbl [NLAYER];
  desc_t         cfg_q;
  logic [2:0]    state;
  logic [LI:0]   n_q;
  logic          abort_q;
  logic [CW-1:0] wcnt;
  logic          last;
  logic          unused_wdata;

  assign unused_wdata = ^cfg_wdata;
  assign last = ({1'b0, cur_layer} == n_q - 1'b1);

  // Host writes land only between runs so a layer's config cannot shift under the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLAYER; i++) tbl[i] <= '0;
    end else if (cfg_we && !busy) begin
      case (cfg_field)
        4'd0:  tbl[cfg_layer].total_in   <= cfg_wdata[LWIDTH-1:0];
        4'd1:  tbl[cfg_layer].total_out  <= cfg_wdata[LWIDTH-1:0];
        4'd2:  tbl[cfg_layer].img_height <= cfg_wdata[LWIDTH-1:0];
        4'd3:  tbl[cfg_layer].img_width  <= cfg_wdata[LWIDTH-1:0];
        4'd4:  tbl[cfg_layer].conv_kern  <= cfg_wdata[LWIDTH-1:0];
        4'd5:  tbl[cfg_layer].conv_strid <= cfg_wdata[LWIDTH-1:0];
        4'd6:  tbl[cfg_layer].conv_pad   <= cfg_wdata[LWIDTH-1:0];
        4'd7:  tbl[cfg_layer].pool_kern  <= cfg_wdata[LWIDTH-1:0];
        4'd8:  tbl[cfg_layer].pool_strid <= cfg_wdata[LWIDTH-1:0];
        4'd9:  tbl[cfg_layer].pool_pad   <= cfg_wdata[LWIDTH-1:0];
        4'd10: begin
          tbl[cfg_layer].pool_en <= cfg_wdata[2];
          tbl[cfg_layer].relu_en <= cfg_wdata[1];
          tbl[cfg_layer].bias_en <= cfg_wdata[0];
        end
        4'd11: tbl[cfg_layer].in_offset  <= cfg_wdata[MEMSIZE-1:0];
        4'd12: tbl[cfg_layer].out_offset <= cfg_wdata[MEMSIZE-1:0];
        4'd13: tbl[cfg_layer].net_offset <= cfg_wdata[NETSIZE-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
      req       <= 1'b0;
      cur_layer <= '0;
      n_q       <= '0;
      abort_q   <= 1'b0;
      wcnt      <= '0;
      cfg_q     <= '0;
    end else begin
      done <= 1'b0;
      req  <= 1'b0;
      if (abort && state != S_IDLE) abort_q <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          n_q       <= (num_layers > NMAX) ? NMAX : num_layers;
          err       <= 1'b0;
          aborted   <= 1'b0;
          abort_q   <= 1'b0;
          cur_layer <= '0;
          busy      <= 1'b1;
          state     <= S_LOAD;
        end
        S_LOAD: if (n_q == '0 || abort_q) begin
          aborted <= abort_q && (n_q != '0);
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= S_DONE;
        end else begin
          cfg_q <= tbl[cur_layer];
          req   <= 1'b1;
          state <= S_REQ;
        end
        S_REQ: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        // The core cannot be cancelled: a pending abort waits for ack or timeout.
        S_WAIT: if (ack) begin
          state <= S_NEXT;
        end else if (wcnt == TO_END) begin
          err   <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        S_NEXT: if (last || abort_q) begin
          aborted <= abort_q && !last;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= S_DONE;
        end else begin
          cur_layer <= cur_layer + 1'b1;
          state     <= S_LOAD;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign total_in   = cfg_q.total_in;
  assign total_out  = cfg_q.total_out;
  assign img_height = cfg_q.img_height;
  assign img_width  = cfg_q.img_width;
  assign conv_kern  = cfg_q.conv_kern;
  assign conv_strid = cfg_q.conv_strid;
  assign conv_pad   = cfg_q.conv_pad;
  assign pool_kern  = cfg_q.pool_kern;
  assign pool_strid = cfg_q.pool_strid;
  assign pool_pad   = cfg_q.pool_pad;
  assign bias_en    = cfg_q.bias_en;
  assign relu_en    = cfg_q.relu_en;
  assign pool_en    = cfg_q.pool_en;
  assign in_offset  = cfg_q.in_offset;
  assign out_offset = cfg_q.out_offset;
  assign net_offset = cfg_q.net_offset;

endmodule

// File: tb/tb_renkon_layer_seq.sv
// Scoreboard bench for renkon_layer_seq: runs are planned from a table model,
// expected req/done events are queued up front and a negedge monitor checks them.
module tb_renkon_layer_seq;
  localparam int NL = 8;
  localparam int TO = 64;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cfg_we = 1'b0, ack = 1'b0;
  logic [3:0]  num_layers = '0;
  logic [2:0]  cfg_layer = '0;
  logic [3:0]  cfg_field = '0;
  logic [15:0] cfg_wdata = '0;
  logic busy, done, err, aborted, req, bias_en, relu_en, pool_en;
  logic [2:0]  cur_layer;
  logic [9:0]  total_in, total_out, img_height, img_width, conv_kern, conv_strid, conv_pad;
  logic [9:0]  pool_kern, pool_strid, pool_pad;
  logic [11:0] in_offset, out_offset;
  logic [10:0] net_offset;

  renkon_layer_seq #(.LWIDTH(10), .MEMSIZE(12), .NETSIZE(11), .NLAYER(NL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .num_layers(num_layers), .abort(abort),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .busy(busy), .done(done), .err(err), .aborted(aborted), .cur_layer(cur_layer),
    .req(req), .ack(ack), .total_in(total_in), .total_out(total_out),
    .img_height(img_height), .img_width(img_width), .conv_kern(conv_kern),
    .conv_strid(conv_strid), .conv_pad(conv_pad), .pool_kern(pool_kern),
    .pool_strid(pool_strid), .pool_pad(pool_pad), .bias_en(bias_en), .relu_en(relu_en),
    .pool_en(pool_en), .in_offset(in_offset), .out_offset(out_offset), .net_offset(net_offset)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int mdl [NL][14];

  typedef struct { int cyc; int layer; logic [13:0][15:0] f; } ereq_t;
  typedef struct { int cyc; bit err; bit ab; } edone_t;
  ereq_t  qreq[$];
  edone_t qdone[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int fw(int f);
    if (f <= 9) return 10;
    if (f == 10) return 3;
    if (f == 13) return 11;
    return 12;
  endfunction

  function automatic int dut_field(int f);
    case (f)
      0: return int'(total_in);    1: return int'(total_out);
      2: return int'(img_height);  3: return int'(img_width);
      4: return int'(conv_kern);   5: return int'(conv_strid);
      6: return int'(conv_pad);    7: return int'(pool_kern);
      8: return int'(pool_strid);  9: return int'(pool_pad);
      10: return int'({pool_en, relu_en, bias_en});
      11: return int'(in_offset); 12: return int'(out_offset);
      default: return int'(net_offset);
    endcase
  endfunction

  always @(negedge clk) begin : mon
    ereq_t  e;
    edone_t dn;
    if (req) begin
      if (qreq.size() == 0) chk("unexpected req", 1, 0);
      else begin
        e = qreq.pop_front();
        chk("req cycle", cyc, e.cyc);
        chk("req layer", int'(cur_layer), e.layer);
        chk("busy at req", int'(busy), 1);
        for (int i = 0; i < 14; i++)
          chk($sformatf("layer %0d field %0d", e.layer, i), dut_field(i), int'(e.f[i]));
      end
    end
    if (done) begin
      if (qdone.size() == 0) chk("unexpected done", 1, 0);
      else begin
        dn = qdone.pop_front();
        chk("done cycle", cyc, dn.cyc);
        chk("err at done", int'(err), int'(dn.err));
        chk("aborted at done", int'(aborted), int'(dn.ab));
        chk("busy at done", int'(busy), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " err"}, int'(err), 0);
    chk({tag, " aborted"}, int'(aborted), 0);
    chk({tag, " req"}, int'(req), 0);
    chk({tag, " cur_layer"}, int'(cur_layer), 0);
    for (int i = 0; i < 14; i++) chk($sformatf("%s field %0d", tag, i), dut_field(i), 0);
  endtask

  task automatic cfg_wr(int l, int f, int v, bit upd);
    cfg_we = 1'b1; cfg_layer = 3'(l); cfg_field = 4'(f); cfg_wdata = 16'(v);
    tick();
    cfg_we = 1'b0;
    if (upd && f < 14) mdl[l][f] = v & ((1 << fw(f)) - 1);
  endtask

  // Plans a whole run from the model, queues the expected events, then plays ack/abort.
  task automatic run(int n_in, int d, int abort_k, int noack_k, bit busy_poke);
    int t, n, r, a, endc, abort_c, hit;
    int acks[$];
    ereq_t  e;
    edone_t dn;
    t = cyc; n = (n_in > NL) ? NL : n_in; abort_c = -1;
    dn = '{t + 2, 1'b0, 1'b0};
    r = t + 2;
    for (int k = 0; k < n; k++) begin
      e.cyc = r; e.layer = k;
      for (int i = 0; i < 14; i++) e.f[i] = 16'(mdl[k][i]);
      qreq.push_back(e);
      if (k == noack_k) begin dn = '{r + 1 + TO, 1'b1, 1'b0}; break; end
      a = r + d;
      acks.push_back(a);
      if (k == abort_k && k != n - 1) begin abort_c = r + 2; dn = '{a + 2, 1'b0, 1'b1}; break; end
      if (k == n - 1) dn = '{a + 2, 1'b0, 1'b0};
      else r = a + 3;
    end
    qdone.push_back(dn);
    endc = dn.cyc + 2;
    start = 1'b1; num_layers = 4'(n_in);
    while (cyc < endc) begin
      tick();
      hit = 0;
      foreach (acks[j]) if (acks[j] == cyc) hit = 1;
      ack = hit[0];
      abort = (cyc == abort_c);
      start = busy_poke && (cyc == t + 3);
      cfg_we = busy_poke && (cyc == t + 3);
      cfg_layer = '0; cfg_field = 4'd2; cfg_wdata = 16'd99;
    end
    start = 1'b0; ack = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    chk("req outstanding", qreq.size(), 0);
    chk("done outstanding", qdone.size(), 0);
  endtask

  task automatic rst_mid_run();
    int t;
    ereq_t e;
    t = cyc;
    e.cyc = t + 2; e.layer = 0;
    for (int i = 0; i < 14; i++) e.f[i] = 16'(mdl[0][i]);
    qreq.push_back(e);
    start = 1'b1; num_layers = 4'd2;
    while (cyc < t + 10) begin
      tick();
      start = 1'b0;
      rst = (cyc == t + 4);
      ack = (cyc == t + 6);
    end
    rst = 1'b0; ack = 1'b0;
    for (int l = 0; l < NL; l++) for (int f = 0; f < 14; f++) mdl[l][f] = 0;
    chk("req outstanding after rst", qreq.size(), 0);
    check_zero("after mid-run rst");
  endtask

  initial begin
    int n, ab;
    for (int l = 0; l < NL; l++) for (int f = 0; f < 14; f++) mdl[l][f] = 0;
    repeat (3) tick();
    check_zero("in reset");
    rst = 1'b0;
    tick();
    check_zero("after reset");

    for (int l = 0; l < NL; l++)
      for (int f = 0; f < 16; f++) cfg_wr(l, f, int'($urandom_range(0, 65535)), 1'b1);
    cfg_wr(1, 0, 3, 1'b1);
    cfg_wr(1, 2, 12, 1'b1);
    cfg_wr(1, 3, 12, 1'b1);
    cfg_wr(1, 10, 7, 1'b1);
    ack = 1'b1; tick(); ack = 1'b0; tick();

    run(3, 5, -1, -1, 1'b0);
    run(0, 5, -1, -1, 1'b0);
    run(4, 5, 1, -1, 1'b0);
    run(2, 5, -1, 0, 1'b0);
    run(2, 4, -1, -1, 1'b1);
    run(1, 3, -1, -1, 1'b0);

    repeat (6) begin
      n  = int'($urandom_range(1, 8));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      cfg_wr(int'($urandom_range(0, NL - 1)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 65535)), 1'b1);
      run(n, int'($urandom_range(3, 9)), ab, -1, 1'b0);
    end

    run(9, 2, -1, -1, 1'b0);
    rst_mid_run();
    run(2, 3, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
